glyph_blit_ctrl: RTL and testbench

//   Sequences an 8x16 one-bit glyph ROM (registered read, 1-cycle latency) and

---
 rtl/glyph_blit_ctrl.sv | 139 +++++++++++++
 tb/tb_glyph_blit_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_blit_ctrl.sv
// Glyph blitter: walks an 8x16 one-bit glyph ROM (1-cycle registered read) and emits
// coloured pixel beats at (org_x+col, org_y+row). Optional build macro: TRANSPARENT_BG_EN.
module glyph_blit_ctrl #(
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 16,
  parameter int ADDR_W  = 7,
  parameter int SEL_W   = 4,
  parameter int X_W     = 9,
  parameter int Y_W     = 9,
  parameter int COLOR_W = 16
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SEL_W-1:0]   glyph_sel,
  input  logic [X_W-1:0]     org_x,
  input  logic [Y_W-1:0]     org_y,
  input  logic [COLOR_W-1:0] fg_color,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic               abort,
  output logic [SEL_W-1:0]   rom_sel,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic               rom_q,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic               done
);

  localparam int CW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int RW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, FIN} state_t;

  state_t             state;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [X_W-1:0]     ox;
  logic [COLOR_W-1:0] fg;
  logic               emit_q;
  logic               step;
  logic               last;

  assign last = (col == CW'(GLYPH_W-1)) && (row == RW'(GLYPH_H-1));

  // rom_addr is held through a stall, so rom_q (and the colour derived from it)
  // stays stable without a separate data register.
`ifdef TRANSPARENT_BG_EN
  logic unused_bg;
  assign unused_bg = ^bg_color;
  assign pix_valid = emit_q & rom_q;
  assign step      = emit_q & (pix_ready | ~rom_q);
  assign pix_color = pix_valid ? fg : '0;
`else
  logic [COLOR_W-1:0] bg;
  assign pix_valid = emit_q;
  assign step      = emit_q & pix_ready;
  assign pix_color = pix_valid ? (rom_q ? fg : bg) : '0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      ox       <= '0;
      fg       <= '0;
`ifndef TRANSPARENT_BG_EN
      bg       <= '0;
`endif
      emit_q   <= 1'b0;
      rom_sel  <= '0;
      rom_addr <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      // abort wins over a same-cycle handshake: that beat never counts
      if (abort && state != IDLE) begin
        state    <= IDLE;
        emit_q   <= 1'b0;
        busy     <= 1'b0;
        col      <= '0;
        row      <= '0;
        rom_addr <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            col      <= '0;
            row      <= '0;
            rom_addr <= '0;
            rom_sel  <= glyph_sel;
            ox       <= org_x;
            pix_x    <= org_x;
            pix_y    <= org_y;
            fg       <= fg_color;
`ifndef TRANSPARENT_BG_EN
            bg       <= bg_color;
`endif
          end
          FETCH: begin
            state  <= EMIT;
            emit_q <= 1'b1;
          end
          EMIT: if (step) begin
            emit_q <= 1'b0;
            if (last) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= FETCH;
              rom_addr <= rom_addr + 1'b1;
              if (col == CW'(GLYPH_W-1)) begin
                col   <= '0;
                row   <= row + 1'b1;
                pix_x <= ox;
                pix_y <= pix_y + 1'b1;
              end else begin
                col   <= col + 1'b1;
                pix_x <= pix_x + 1'b1;
              end
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glyph_blit_ctrl.sv
// Randomized bench for glyph_blit_ctrl: glyph ROM model plus an expected-beat list built
// straight from the glyph bitmap and origin arithmetic.
module tb_glyph_blit_ctrl;

  typedef struct packed {
    logic [6:0]  a;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] c;
  } beat_t;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  glyph_sel = '0;
  logic [8:0]  org_x = '0, org_y = '0;
  logic [15:0] fg_color = '0, bg_color = '0;
  logic        abort = 1'b0;
  logic [3:0]  rom_sel;
  logic [6:0]  rom_addr;
  logic        rom_q = 1'b0;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_color;
  logic        busy, done;

  int    checks = 0, errors = 0;
  int    done_cnt = 0, stall_err = 0;
  bit    rdy_rand = 1'b0;
  beat_t beats[$];
  beat_t exp_q[$];
  logic [7:0] rom [16][16];
  logic [7:0] g3  [16] = '{8'h00, 8'h00, 8'h00, 8'h3E, 8'h42, 8'h06, 8'h06, 8'h3C,
                           8'h06, 8'h06, 8'h66, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};

  glyph_blit_ctrl dut (
    .clock(clock), .rst_n(rst_n), .start(start), .glyph_sel(glyph_sel),
    .org_x(org_x), .org_y(org_y), .fg_color(fg_color), .bg_color(bg_color),
    .abort(abort), .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_q(rom_q),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_q <= rom[rom_sel][rom_addr[6:3]][7 - rom_addr[2:0]];

  initial begin : rdy_drv
    forever begin
      @(posedge clock); #1;
      pix_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Records accepted beats and flags any stalled beat that changes before acceptance.
  initial begin : mon
    beat_t cur, prv;
    bit    prv_stall;
    prv_stall = 1'b0;
    prv = '0;
    forever begin
      @(negedge clock);
      cur.a = rom_addr; cur.x = pix_x; cur.y = pix_y; cur.c = pix_color;
      if (!rst_n) prv_stall = 1'b0;
      else begin
        if (prv_stall && (pix_valid !== 1'b1 || cur !== prv)) stall_err++;
        if (done) done_cnt++;
        if (pix_valid && pix_ready && !abort) beats.push_back(cur);
        prv_stall = pix_valid && !pix_ready && !abort;
        prv = cur;
      end
    end
  end

  task automatic build_exp(input int sel, input logic [8:0] ox, input logic [8:0] oy,
                           input logic [15:0] fg, input logic [15:0] bg);
    beat_t e;
    bit    b;
    exp_q.delete();
    for (int a = 0; a < 128; a++) begin
      b = rom[sel][a / 8][7 - (a % 8)];
      e.a = 7'(a); e.x = 9'(ox + (a % 8)); e.y = 9'(oy + (a / 8)); e.c = b ? fg : bg;
`ifdef TRANSPARENT_BG_EN
      if (b) exp_q.push_back(e);
`else
      exp_q.push_back(e);
`endif
    end
  endtask

  task automatic start_glyph(input int sel, input logic [8:0] ox, input logic [8:0] oy,
                             input logic [15:0] fg, input logic [15:0] bg);
    build_exp(sel, ox, oy, fg, bg);
    @(posedge clock); #1;
    beats.delete(); done_cnt = 0;
    glyph_sel = 4'(sel); org_x = ox; org_y = oy; fg_color = fg; bg_color = bg; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit to);
    to = 1'b1; lat = 0;
    for (int k = 1; k <= 5000; k++) begin
      @(posedge clock); #1;
      if (done) begin lat = k + 1; to = 1'b0; break; end
    end
  endtask

  task automatic wait_beats(input int n, output bit to);
    to = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clock); #1;
      if (beats.size() >= n) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    #23;
    checks++;
    if ({rom_sel, rom_addr, pix_valid, pix_x, pix_y, pix_color, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got sel=%h addr=%h v=%b x=%h y=%h c=%h busy=%b done=%b want all 0",
               rom_sel, rom_addr, pix_valid, pix_x, pix_y, pix_color, busy, done);
    end
    @(posedge clock); #1; rst_n = 1'b1;
    repeat (2) @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || pix_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got busy=%b v=%b want 0 0", busy, pix_valid);
    end
  endtask

  task automatic test_basic;
    int lat; bit to;
    rdy_rand = 1'b0;
    start_glyph(3, 9'd100, 9'd50, 16'hFFFF, 16'h0000);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_done(lat, to);
    checks++;
    if (to || lat != 257) begin
      errors++; $display("FAIL basic_latency got %0d (timeout=%0d) want 257", lat, to);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fin got %b want 0", busy); end
    repeat (3) @(posedge clock); #1;
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
    checks++;
    if (beats.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_count got %0d want %0d", beats.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_beat%0d got %h want %h", i, beats[i], exp_q[i]);
      end
    end
`ifdef TRANSPARENT_BG_EN
    checks++;
    if (beats.size() != 27 || beats[0].a !== 7'd26) begin
      errors++; $display("FAIL transp_g3 got count=%0d first_addr=%0d want 27 26", beats.size(), beats[0].a);
    end
`else
    checks++;
    if (beats[25] !== {7'd25, 9'd101, 9'd53, 16'h0000}) begin
      errors++; $display("FAIL g3_beat25 got %h want %h", beats[25], {7'd25, 9'd101, 9'd53, 16'h0000});
    end
    for (int i = 26; i <= 29; i++) begin
      checks++;
      if (beats[i].x !== 9'(i + 76) || beats[i].y !== 9'd53 || beats[i].c !== 16'hFFFF) begin
        errors++; $display("FAIL g3_beat%0d got %h want x=%0d y=53 c=FFFF", i, beats[i], i + 76);
      end
    end
`endif
  endtask

  task automatic test_stall;
    int lat; bit to; int sel;
    rdy_rand = 1'b1;
    stall_err = 0;
    for (int g = 0; g < 3; g++) begin
      sel = (g == 0) ? 3 : int'($urandom_range(1, 14));
      if (g == 0) start_glyph(3, 9'd100, 9'd50, 16'hFFFF, 16'h0000);
      else start_glyph(sel, 9'($urandom), 9'($urandom), 16'($urandom), 16'($urandom));
      wait_done(lat, to);
      checks++;
      if (to) begin errors++; $display("FAIL stall_done%0d got timeout want done", g); end
      checks++;
      if (beats.size() != exp_q.size()) begin
        errors++; $display("FAIL stall_count%0d got %0d want %0d", g, beats.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
        checks++;
        if (beats[i] !== exp_q[i]) begin
          errors++; $display("FAIL stall_beat%0d_%0d got %h want %h", g, i, beats[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", stall_err); end
    rdy_rand = 1'b0;
  endtask

  task automatic test_wrap;
    int lat; bit to;
    start_glyph(15, 9'd510, 9'd511, 16'($urandom), 16'($urandom));
    wait_done(lat, to);
    checks++;
    if (to || beats.size() != exp_q.size()) begin
      errors++; $display("FAIL wrap_count got %0d (timeout=%0d) want %0d", beats.size(), to, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== exp_q[i]) begin
        errors++; $display("FAIL wrap_beat%0d got %h want %h", i, beats[i], exp_q[i]);
      end
    end
    checks++;
    if (beats[1].x !== 9'd511 || beats[2].x !== 9'd0 || beats[7].x !== 9'd5 || beats[8].y !== 9'd0) begin
      errors++; $display("FAIL wrap_edges got x1=%0d x2=%0d x7=%0d y8=%0d want 511 0 5 0",
                         beats[1].x, beats[2].x, beats[7].x, beats[8].y);
    end
  endtask

  task automatic test_start_ignored;
    int lat; bit to;
    start_glyph(15, 9'($urandom), 9'($urandom), 16'($urandom), 16'($urandom));
    wait_beats(40, to);
    glyph_sel = 4'd3; org_x = 9'd7; org_y = 9'd9; fg_color = 16'h1234; bg_color = 16'h4321;
    start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    wait_done(lat, to);
    repeat (3) @(posedge clock); #1;
    checks++;
    if (to || done_cnt != 1) begin
      errors++; $display("FAIL ign_done got %0d (timeout=%0d) want 1", done_cnt, to);
    end
    checks++;
    if (beats.size() != exp_q.size()) begin
      errors++; $display("FAIL ign_count got %0d want %0d", beats.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== exp_q[i]) begin
        errors++; $display("FAIL ign_beat%0d got %h want %h", i, beats[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort;
    bit to;
    start_glyph(15, 9'($urandom), 9'($urandom), 16'($urandom), 16'($urandom));
    wait_beats(60, to);
    abort = 1'b1;
    @(posedge clock); #1; abort = 1'b0;
    checks++;
    if (to || busy !== 1'b0 || pix_valid !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b v=%b (timeout=%0d) want 0 0", busy, pix_valid, to);
    end
    repeat (300) @(posedge clock); #1;
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
    checks++;
    if (beats.size() != 60) begin errors++; $display("FAIL abort_count got %0d want 60", beats.size()); end
  endtask

  task automatic test_reset_mid;
    int lat; bit to;
    logic [8:0] ox, oy; logic [15:0] fg;
    start_glyph(15, 9'($urandom), 9'($urandom), 16'($urandom), 16'($urandom));
    wait_beats(70, to);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (to || {rom_sel, rom_addr, pix_valid, pix_x, pix_y, pix_color, busy, done} !== '0) begin
      errors++; $display("FAIL rst_mid got v=%b busy=%b x=%h y=%h c=%h addr=%h (timeout=%0d) want all 0",
                         pix_valid, busy, pix_x, pix_y, pix_color, rom_addr, to);
    end
    repeat (2) @(posedge clock); #1; rst_n = 1'b1;
    repeat (3) @(posedge clock); #1;
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", done_cnt); end
    ox = 9'($urandom); oy = 9'($urandom); fg = 16'($urandom);
    start_glyph(15, ox, oy, fg, 16'($urandom));
    wait_beats(1, to);
    checks++;
    if (to || beats[0] !== {7'd0, ox, oy, fg}) begin
      errors++; $display("FAIL rst_first_beat got %h want %h", beats[0], {7'd0, ox, oy, fg});
    end
    wait_done(lat, to);
    checks++;
    if (to || beats.size() != exp_q.size()) begin
      errors++; $display("FAIL rst_restart_count got %0d want %0d", beats.size(), exp_q.size());
    end
  endtask

  task automatic test_zero_and_fin_start;
    int lat; bit to;
    start_glyph(0, 9'($urandom), 9'($urandom), 16'($urandom), 16'($urandom));
    wait_done(lat, to);
    checks++;
    if (to || lat != 257) begin
      errors++; $display("FAIL zero_latency got %0d (timeout=%0d) want 257", lat, to);
    end
    // start raised only in the FIN cycle must be dropped
    start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (3) @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      errors++; $display("FAIL fin_start got busy=%b done_cnt=%0d want 0 1", busy, done_cnt);
    end
    checks++;
    if (beats.size() != exp_q.size()) begin
      errors++; $display("FAIL zero_count got %0d want %0d", beats.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== exp_q[i]) begin
        errors++; $display("FAIL zero_beat%0d got %h want %h", i, beats[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 16; s++)
      for (int r = 0; r < 16; r++)
        rom[s][r] = (s == 0) ? 8'h00 : (s == 15) ? 8'hFF : (s == 3) ? g3[r] : 8'($urandom);
    test_reset;
    test_basic;
    test_stall;
    test_wrap;
    test_start_ignored;
    test_abort;
    test_reset_mid;
    test_zero_and_fin_start;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
